// File: rtl/mips16_pkg.sv
// mips16_pkg: opcodes, instruction field positions and encoder FSM states.
// Shared by instr_field_pack and instr_encoder.
package mips16_pkg;
  localparam int INSTR_W = 16;
  localparam int OP_W = 3;
  localparam int REG_W = 3;
  localparam int FUNCT_W = 4;
  localparam int IMM_W = 7;
  localparam int JADDR_W = 13;
  localparam int OP_MSB = 15;
  localparam int RS_MSB = 12;
  localparam int RT_MSB = 9;
  localparam int RD_MSB = 6;
  localparam int FUNCT_MSB = 3;
  localparam int IMM_MSB = 6;
  localparam int JADDR_MSB = 12;
  typedef enum logic [2:0] {
    OP_R, OP_SLTI, OP_J, OP_JAL, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  } opcode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_FULL} state_t;
endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: packs decoded fields into a 16-bit instruction word.
// Ports: opcode/rs/rt/rd/funct/imm/jaddr in, word out (combinational).
module instr_field_pack
  import mips16_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [IMM_W-1:0]   imm,
  input  logic [JADDR_W-1:0] jaddr,
  output logic [INSTR_W-1:0] word
);
  always_comb begin
    word = '0;
    word[OP_MSB -: OP_W] = opcode;
    if (opcode == OP_J || opcode == OP_JAL) word[JADDR_MSB -: JADDR_W] = jaddr;
    else begin
      word[RS_MSB -: REG_W] = rs;
      word[RT_MSB -: REG_W] = rt;
      if (opcode == OP_R) begin
        word[RD_MSB -: REG_W] = rd;
        word[FUNCT_MSB -: FUNCT_W] = funct;
      end else word[IMM_MSB -: IMM_W] = imm;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes instruction fields and streams them into instruction memory.
// Ports: start/start_addr/stop session control; in_* valid/ready field input;
// imem_we/addr/wdata/ready memory write; busy/full/done/count status.
module instr_encoder
  import mips16_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [3:0]        in_funct,
  input  logic [6:0]        in_imm,
  input  logic [12:0]       in_jaddr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic [ADDR_W:0]   count
);
  state_t state, next;
  logic out_v, skid_v, done_r;
  logic [15:0] out_d, skid_d, word;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] cnt;
  logic acc, wr, last;
  instr_field_pack pack (
    .opcode(in_opcode),
    .rs(in_rs),
    .rt(in_rt),
    .rd(in_rd),
    .funct(in_funct),
    .imm(in_imm),
    .jaddr(in_jaddr),
    .word(word)
  );
  assign acc = in_valid && in_ready;
  assign wr = out_v && imem_ready;
  // the write to the top address fills memory; anything still buffered is dropped
  assign last = wr && (&addr);
  assign imem_we = out_v;
  assign imem_addr = addr;
  assign imem_wdata = out_d;
  assign count = cnt;
  assign done = done_r;
  always_ff @(posedge clk) state <= reset ? ST_IDLE : next;
  always_comb begin
    next = state;
    if (state == ST_IDLE && start) next = ST_LOAD;
    else if ((state == ST_LOAD || state == ST_DRAIN) && last) next = ST_FULL;
    else if (state == ST_LOAD && stop) next = ST_DRAIN;
    else if (state == ST_DRAIN && !out_v && !skid_v) next = ST_IDLE;
    else if (state == ST_FULL && stop) next = ST_IDLE;
  end
  always_comb begin
    in_ready = state == ST_LOAD && !skid_v;
    busy = state != ST_IDLE;
    full = state == ST_FULL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
      out_d <= '0;
      skid_d <= '0;
      addr <= '0;
      cnt <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == ST_DRAIN || state == ST_FULL) && next == ST_IDLE;
      if (state == ST_IDLE && start) begin
        addr <= start_addr;
        cnt <= '0;
      end else if (wr) begin
        addr <= addr + 1'b1;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        out_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (wr) begin
        out_v <= skid_v || acc;
        out_d <= skid_v ? skid_d : word;
        skid_v <= 1'b0;
      end else if (acc && out_v) begin
        skid_v <= 1'b1;
        skid_d <= word;
      end else if (acc) begin
        out_v <= 1'b1;
        out_d <= word;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of instr_encoder at ADDR_W=8 and ADDR_W=2.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] in_opcode = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic [3:0] in_funct = '0;
  logic [6:0] in_imm = '0;
  logic [12:0] in_jaddr = '0;
  logic start = 0, stop = 0, in_valid = 0, imem_ready = 1;
  logic [7:0] start_addr = '0;
  logic in_ready, imem_we, busy, full, done;
  logic [7:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0] count;
  logic start_b = 0, stop_b = 0, in_valid_b = 0, imem_ready_b = 1;
  logic [1:0] start_addr_b = '0;
  logic in_ready_b, imem_we_b, busy_b, full_b, done_b;
  logic [1:0] imem_addr_b;
  logic [15:0] imem_wdata_b;
  logic [2:0] count_b;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_jaddr(in_jaddr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .full(full),
    .done(done), .count(count)
  );
  instr_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .start_addr(start_addr_b), .stop(stop_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_opcode(in_opcode), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_jaddr(in_jaddr), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .imem_ready(imem_ready_b), .busy(busy_b), .full(full_b),
    .done(done_b), .count(count_b)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fields(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [3:0] fn, input logic [6:0] imm,
                        input logic [12:0] ja);
    in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = imm; in_jaddr = ja;
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    start = 1; start_addr = 8'h10;
    tick();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    chk("start_addr", imem_addr, 8'h10);
    chk("start_we", imem_we, 0);
    in_valid = 1; fields(3'b000, 2, 3, 1, 0, 0, 0);
    tick();
    in_valid = 0;
    chk("r_we", imem_we, 1);
    chk("r_addr", imem_addr, 8'h10);
    chk("r_wdata", imem_wdata, 16'h0990);
    tick();
    chk("r_we_off", imem_we, 0);
    chk("r_addr_inc", imem_addr, 8'h11);
    chk("r_count", count, 1);
    in_valid = 1; fields(3'b100, 2, 1, 0, 0, 5, 0);
    tick();
    chk("lw_we", imem_we, 1);
    chk("lw_addr", imem_addr, 8'h11);
    chk("lw_wdata", imem_wdata, 16'h8885);
    fields(3'b010, 0, 0, 0, 0, 0, 13'h0123);
    tick();
    in_valid = 0;
    chk("j_addr", imem_addr, 8'h12);
    chk("j_wdata", imem_wdata, 16'h4123);
    chk("lw_count", count, 2);
    tick();
    chk("j_we_off", imem_we, 0);
    chk("j_addr_inc", imem_addr, 8'h13);
    chk("j_count", count, 3);
    imem_ready = 0; in_valid = 1; fields(3'b111, 1, 2, 0, 0, 7, 0);
    tick();
    fields(3'b101, 3, 4, 0, 0, 7'h11, 0);
    chk("st_we", imem_we, 1);
    chk("st_wdata0", imem_wdata, 16'hE507);
    chk("st_ready0", in_ready, 1);
    tick();
    fields(3'b110, 5, 6, 0, 0, 7'h7f, 0);
    chk("st_ready1", in_ready, 0);
    chk("st_wdata1", imem_wdata, 16'hE507);
    chk("st_addr1", imem_addr, 8'h13);
    tick();
    chk("st_ready2", in_ready, 0);
    chk("st_wdata2", imem_wdata, 16'hE507);
    imem_ready = 1;
    tick();
    chk("st_wdata3", imem_wdata, 16'hAE11);
    chk("st_addr3", imem_addr, 8'h14);
    chk("st_count3", count, 4);
    chk("st_ready3", in_ready, 1);
    tick();
    in_valid = 0;
    chk("st_wdata4", imem_wdata, 16'hD77F);
    chk("st_addr4", imem_addr, 8'h15);
    chk("st_count4", count, 5);
    tick();
    chk("st_addr5", imem_addr, 8'h16);
    chk("st_count5", count, 6);
    chk("st_we5", imem_we, 0);
    imem_ready = 0; in_valid = 1; fields(3'b111, 1, 2, 0, 0, 7, 0);
    tick();
    fields(3'b101, 3, 4, 0, 0, 7'h11, 0);
    tick();
    in_valid = 0; stop = 1;
    tick();
    stop = 0;
    chk("dr_in_ready", in_ready, 0);
    chk("dr_busy", busy, 1);
    chk("dr_wdata0", imem_wdata, 16'hE507);
    imem_ready = 1;
    tick();
    chk("dr_addr1", imem_addr, 8'h17);
    chk("dr_wdata1", imem_wdata, 16'hAE11);
    chk("dr_done1", done, 0);
    tick();
    chk("dr_addr2", imem_addr, 8'h18);
    chk("dr_count2", count, 8);
    chk("dr_we2", imem_we, 0);
    chk("dr_done2", done, 0);
    tick();
    chk("dr_done3", done, 1);
    chk("dr_busy3", busy, 0);
    tick();
    chk("dr_done4", done, 0);
    chk("dr_count4", count, 8);
    start = 1; start_addr = 8'h40;
    tick();
    start = 0; imem_ready = 0; in_valid = 1; fields(3'b111, 1, 2, 0, 0, 7, 0);
    tick();
    in_valid = 0;
    chk("mr_we", imem_we, 1);
    reset = 1;
    tick();
    reset = 0; imem_ready = 1;
    chk("mr_we_off", imem_we, 0);
    chk("mr_busy", busy, 0);
    chk("mr_count", count, 0);
    chk("mr_done", done, 0);
    chk("mr_addr", imem_addr, 0);
    tick();
    chk("mr_done1", done, 0);
    chk("mr_we1", imem_we, 0);
    start_b = 1; start_addr_b = 2'd3;
    tick();
    start_b = 0; in_valid_b = 1; fields(3'b000, 2, 3, 1, 0, 0, 0);
    tick();
    fields(3'b100, 2, 1, 0, 0, 5, 0);
    chk("fb_we", imem_we_b, 1);
    chk("fb_addr", imem_addr_b, 3);
    chk("fb_wdata", imem_wdata_b, 16'h0990);
    tick();
    in_valid_b = 0;
    chk("fb_full", full_b, 1);
    chk("fb_in_ready", in_ready_b, 0);
    chk("fb_we_off", imem_we_b, 0);
    chk("fb_count", count_b, 1);
    tick();
    chk("fb_we_hold", imem_we_b, 0);
    chk("fb_count_hold", count_b, 1);
    stop_b = 1;
    tick();
    stop_b = 0;
    chk("fb_done", done_b, 1);
    chk("fb_busy", busy_b, 0);
    chk("fb_full_off", full_b, 0);
    tick();
    chk("fb_done_off", done_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle pulse that begins a load session.
REQ-005 SHALL have port start_addr  in  ADDR_W  first instruction-memory address of the session.
REQ-006 SHALL have port stop  in  1  one-cycle pulse that ends the session.
REQ-007 SHALL have port in_valid  in  1  instruction fields valid.
REQ-008 SHALL have port in_ready  out  1  encoder accepts fields this cycle.
REQ-009 SHALL have port in_opcode  in  3  opcodes: 000 R-type, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
REQ-010 SHALL have ports in_rs, in_rt, in_rd  in  3 each  register indices.
REQ-011 SHALL have ports in_funct  in  4, in_imm  in  7, in_jaddr  in  13  operand fields.
REQ-012 SHALL have ports imem_we  out  1, imem_addr  out  ADDR_W, imem_wdata  out  16  memory write request.
REQ-013 SHALL have port imem_ready  in  1  memory accepts the write this cycle.
REQ-014 SHALL have ports busy  out  1, full  out  1, done  out  1, count  out  ADDR_W+1  session status.

Function
REQ-015 SHALL implement FSM IDLE, LOAD, DRAIN, FULL.
REQ-016 SHALL move IDLE->LOAD on start; load imem_addr with start_addr and clear count; start is ignored outside IDLE, and stop is ignored in IDLE.
REQ-017 SHALL encode words as follows:
- R-type (000): {op,rs,rt,rd,funct}.
- slti/lw/sw/beq/addi: {op,rs,rt,imm}.
- j/jal: {op,jaddr}.
- Fields unused by an opcode are don't-care.
REQ-018 SHALL hold a 2-entry buffer: an output register driving imem_wdata and a skid register.
REQ-019 SHALL drive in_ready = (state==LOAD) && skid register empty.
REQ-020 SHALL complete a transfer when in_valid && in_ready, with imem_we asserted the following cycle if the output register is empty (latency 1).
REQ-021 SHALL assert imem_we whenever the output register holds a word; a write completes on imem_we && imem_ready.
REQ-022 SHALL hold imem_wdata and imem_addr stable while imem_we && !imem_ready.
REQ-023 SHALL, on each completed write, increment imem_addr modulo 2^ADDR_W and increment count.
REQ-024 SHALL, when a write completes at address 2^ADDR_W-1, enter FULL:
- Deassert in_ready and assert full.
- Discard any skid word.
REQ-025 SHALL, on stop in LOAD, enter DRAIN, accepting a transfer that completes in the same cycle as stop.
REQ-026 SHALL deassert in_ready in DRAIN and flush the buffered words to memory, then go to IDLE.
REQ-027 SHALL go FULL->IDLE on stop.
REQ-028 SHALL pulse done for exactly one cycle on every entry to IDLE from DRAIN or FULL.
REQ-029 SHALL assert busy in every state except IDLE; count holds its value in IDLE until the next start.

Reset
REQ-030 SHALL, on reset, enter IDLE, empty both buffer entries, and drive:
- in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
- busy=0, full=0, done=0, count=0.
REQ-031 SHALL, on reset mid-session, drop buffered words without writing them and assert no done pulse.

Structure
REQ-032 SHALL take the opcode constants, instruction field bit positions and FSM state encoding from shared package mips16_pkg.
REQ-033 SHALL place field packing in combinational sub-module instr_field_pack, used once.

Verification
REQ-034 SHALL cover: start_addr=0x10, R-type rs=2 rt=3 rd=1 funct=0 -> imem_we one cycle after acceptance, addr 0x10, wdata 0x0990.
REQ-035 SHALL cover: lw rs=2 rt=1 imm=5 then j jaddr=0x0123 back-to-back -> wdata 0x8885 at addr A, 0x4123 at A+1, count=2.
REQ-036 SHALL cover: imem_ready=0 for 3 cycles with in_valid held -> in_ready drops after the skid fills, wdata stable, no word lost or duplicated.
REQ-037 SHALL cover: ADDR_W=2, start_addr=3, two words offered -> single write at addr 3, full=1, in_ready=0; then stop -> done pulse, IDLE.
REQ-038 SHALL cover: stop with both buffer entries valid -> two writes, then exactly one done pulse.
REQ-039 SHALL cover: reset asserted while imem_we=1 and imem_ready=0 -> next cycle imem_we=0, busy=0, count=0, no done pulse.
